seg_scan_driver: RTL

- Parametrised multi-digit seven-segment scan driver that replaces the fixed 8-digit scanner on the board top.
- Takes a packed hex value plus per-digit decimal points from game or debug logic.
- Double-buffers each update and commits it only at a frame boundary, so the display never tears.
- Drives one-hot digit select and segment lines, with configurable polarity, scan rate, digit count and a blank input.

---
 rtl/seg_scan_driver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Multiplexed seven-segment scan driver for DIGIT_CNT digits. A new value is
// captured into a pending buffer on load_i and only copied to the display
// buffer on the frame boundary (the tick where the scan index wraps back to
// digit 0). A half-updated frame is therefore never shown.
//
// Optional build macro:
//   SEG_SCAN_LZ_BLANK_EN - leading-zero suppression. Digits k>0 whose nibble
//                          and all higher nibbles are zero show no segments
//                          a..g. Their dp bit is still shown. Without the
//                          macro, every digit shows its nibble.
//
// Parameters:
//   DIGIT_CNT        number of digits scanned (1..16)
//   SCAN_DIV         clock cycles each digit stays lit (>=2)
//   SEG_ACTIVE_HIGH  1: segment lit on 1, 0: lit on 0
//   SEL_ACTIVE_HIGH  1: digit selected on 1, 0: selected on 0
//
// Ports:
//   clk_100M    system clock
//   reset_n     asynchronous reset, active-low
//   number_i    packed hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   dp_i        decimal point per digit, 1 = lit
//   load_i      one-cycle strobe capturing number_i/dp_i into pending buffer
//   blank_i     1 = all segments and dp dark (scan keeps running)
//   seg_o       {dp,g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_HIGH
//   sel_o       one-hot digit select, registered, polarity per SEL_ACTIVE_HIGH
//   upd_done_o  one-cycle pulse after pending buffer is committed
//   pending_o   1 while a captured value awaits commit
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIGIT_CNT       = 8,
    parameter int SCAN_DIV        = 12500,
    parameter int SEG_ACTIVE_HIGH = 1,
    parameter int SEL_ACTIVE_HIGH = 1
) (
    input  logic                   clk_100M,
    input  logic                   reset_n,
    input  logic [4*DIGIT_CNT-1:0] number_i,
    input  logic [DIGIT_CNT-1:0]   dp_i,
    input  logic                   load_i,
    input  logic                   blank_i,
    output logic [7:0]             seg_o,
    output logic [DIGIT_CNT-1:0]   sel_o,
    output logic                   upd_done_o,
    output logic                   pending_o
);

    localparam int IDX_W = (DIGIT_CNT > 1) ? $clog2(DIGIT_CNT) : 1;
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DIGIT_CNT - 1);
    // Inactive (dark) levels of the output lines for the chosen polarity.
    localparam logic [7:0]           SEG_IDLE = {8{SEG_ACTIVE_HIGH == 0}};
    localparam logic [DIGIT_CNT-1:0] SEL_IDLE = {DIGIT_CNT{SEL_ACTIVE_HIGH == 0}};

    // Hex to segment decode, active-high, bit0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // State registers
    logic [PS_W-1:0]        prescale_reg, prescale_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [4*DIGIT_CNT-1:0] pend_num_reg, pend_num_next;
    logic [DIGIT_CNT-1:0]   pend_dp_reg, pend_dp_next;
    logic                   pending_reg, pending_next;
    logic [4*DIGIT_CNT-1:0] disp_num_reg, disp_num_next;
    logic [DIGIT_CNT-1:0]   disp_dp_reg, disp_dp_next;
    logic                   upd_done_reg, upd_done_next;
    logic [7:0]             seg_reg, seg_next;
    logic [DIGIT_CNT-1:0]   sel_reg, sel_next;

    // Combinational helpers
    logic                   tick;
    logic                   frame_tick;
    logic                   commit;
    logic [DIGIT_CNT-1:0]   sel_onehot;
    logic [DIGIT_CNT-1:0]   suppress;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_sup;
    logic [7:0]             seg_raw;

    // Per-digit select decode and leading-zero mask.
    for (genvar gi = 0; gi < DIGIT_CNT; gi++) begin : g_digit
        assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (gi == 0) begin : g_lsd
            // The rightmost digit always shows, so a value of zero reads "0".
            assign suppress[gi] = 1'b0;
        end else begin : g_upper
            // Dark when this nibble and every nibble above it are zero.
            assign suppress[gi] = (disp_num_reg[4*DIGIT_CNT-1:4*gi] == '0);
        end
`else
        assign suppress[gi] = 1'b0;
`endif
    end

    // Scan timing and buffer control
    always_comb begin
        tick       = (prescale_reg == PS_LAST);
        frame_tick = tick && (idx_reg == IDX_LAST);
        commit     = frame_tick && pending_reg;

        prescale_next = tick ? '0 : prescale_reg + 1'b1;

        idx_next = idx_reg;
        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        // The commit reads the pending buffer before this edge, so a load in
        // the same cycle is captured for the following frame.
        pend_num_next = load_i ? number_i : pend_num_reg;
        pend_dp_next  = load_i ? dp_i     : pend_dp_reg;
        pending_next  = pending_reg;
        if (load_i) begin
            pending_next = 1'b1;
        end else if (commit) begin
            pending_next = 1'b0;
        end

        disp_num_next = commit ? pend_num_reg : disp_num_reg;
        disp_dp_next  = commit ? pend_dp_reg  : disp_dp_reg;
        upd_done_next = commit;
    end

    // Output content for the digit currently indexed
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        for (int k = 0; k < DIGIT_CNT; k++) begin
            if (idx_reg == IDX_W'(k)) begin
                cur_nib = disp_num_reg[4*k +: 4];
                cur_dp  = disp_dp_reg[k];
                cur_sup = suppress[k];
            end
        end

        seg_raw = {cur_dp, cur_sup ? 7'h00 : hex_to_seg(cur_nib)};
        if (blank_i) begin
            seg_raw = 8'h00;
        end

        seg_next = (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
        sel_next = (SEL_ACTIVE_HIGH != 0) ? sel_onehot : ~sel_onehot;
    end

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            prescale_reg <= '0;
            idx_reg      <= '0;
            pend_num_reg <= '0;
            pend_dp_reg  <= '0;
            pending_reg  <= 1'b0;
            disp_num_reg <= '0;
            disp_dp_reg  <= '0;
            upd_done_reg <= 1'b0;
            seg_reg      <= SEG_IDLE;
            sel_reg      <= SEL_IDLE;
        end else begin
            prescale_reg <= prescale_next;
            idx_reg      <= idx_next;
            pend_num_reg <= pend_num_next;
            pend_dp_reg  <= pend_dp_next;
            pending_reg  <= pending_next;
            disp_num_reg <= disp_num_next;
            disp_dp_reg  <= disp_dp_next;
            upd_done_reg <= upd_done_next;
            seg_reg      <= seg_next;
            sel_reg      <= sel_next;
        end
    end

    assign seg_o      = seg_reg;
    assign sel_o      = sel_reg;
    assign upd_done_o = upd_done_reg;
    assign pending_o  = pending_reg;

endmodule
